sm4_round_ctrl: RTL
===================

Name: sm4_round_ctrl

Overview:
Sequencer that drives one SM4 round datapath (XOR, four registered S-boxes, L transform) through all rounds of a 128-bit block encryption or decryption. It accepts a block over a valid/ready handshake and fetches round keys by index from an external key store. It applies the final reverse transform R and presents the result over a valid/ready handshake. It sits between the bus-side block buffer and the key-expansion RAM.

Parameters:
ROUNDS, 32, number of rounds executed; legal range 1..32; values below 32 are for reduced-round debug only.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST_N  input  1  asynchronous active-low reset.
IN_VALID  input  1  input block valid.
IN_READY  output  1  controller can accept a block.
IN_DATA  input  128  block X0..X3; X0 = [127:96].
IN_DEC  input  1  1 = decrypt (reverse key order), sampled on accept.
RK_IDX  output  5  round-key index requested.
RK  input  32  round key for RK_IDX; combinational, valid in the same cycle.
OUT_VALID  output  1  result valid.
OUT_READY  input  1  downstream accepts result.
OUT_DATA  output  128  {X35,X34,X33,X32} after reverse transform R.
BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, RST_N=0): state=IDLE; IN_READY=1, OUT_VALID=0, BUSY=0, OUT_DATA=0, RK_IDX=0; round counter=0; X registers=0. Reset mid-block discards the block silently.
- State machine: IDLE, RND_A, RND_B, DONE.
- IDLE: IN_READY=1. On IN_VALID&IN_READY at cycle T, load X0..X3 from IN_DATA, latch IN_DEC into dec_q, set rnd=0, and go to RND_A.
- RND_A, phase 0: RK_IDX = dec_q ? 31-rnd : rnd. Present X1^X2^X3^RK to the S-boxes, which register the value at the clock edge. Go to RND_B.
- RND_B, phase 1: compute new = X0 ^ L(sbox_out), with L(B) = B ^ B<<<2 ^ B<<<10 ^ B<<<18 ^ B<<<24.
  - Shift: X0<=X1, X1<=X2, X2<=X3, X3<=new.
  - If rnd==ROUNDS-1, go to DONE; otherwise rnd<=rnd+1 and go to RND_A.
- RK_IDX holds its last value outside RND_A. RK is ignored outside RND_A.
- Each round takes 2 cycles. With ROUNDS=32, the last update lands at edge T+64 and OUT_VALID=1 from cycle T+65.
- DONE: OUT_VALID=1; OUT_DATA={X3,X2,X1,X0} of the register file, held stable until the handshake. On OUT_VALID&OUT_READY, go to IDLE. IN_READY=0 in DONE, so there are no back-to-back accepts; the earliest next accept is the cycle after output handshake.
- IN_READY=0 in RND_A, RND_B and DONE. IN_VALID there is ignored and the block is not consumed.
- Round counter is 5 bits. When ROUNDS=32 the counter is never incremented past 31, so there is no wrap.
- OUT_DATA is a register. BUSY = (state != IDLE).

Optional Feature:
Macro SM4_BLK_CNT_EN.
- Defined: adds output port BLK_CNT[31:0], reset to 0. It increments by 1 on each OUT_VALID&OUT_READY and wraps from 0xFFFFFFFF to 0.
- Not defined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Shared package sm4_pkg:
  - state encoding (IDLE=2'd0, RND_A=2'd1, RND_B=2'd2, DONE=2'd3);
  - SM4_NR=32;
  - 128-bit block type;
  - L-transform rotate constants 2/10/18/24.
- One sub-module: sm4_round_dp. It contains the XOR, four registered S-box instances and the L transform, with inputs X0..X3/RK and 32-bit output new. The controller keeps state, counter, X registers and handshakes.

Test Plan:
- Encrypt standard vector:
  - Stimulus: IN_DATA=0123456789abcdeffedcba9876543210, IN_DEC=0. Key store is loaded from key 0123456789abcdeffedcba9876543210, so rk0=f12186f9 and rk31=9124a012.
  - Required response: OUT_DATA=681edf34d206965e86b3e94f536e4246; OUT_VALID rises exactly 65 cycles after accept; RK_IDX steps 0..31.
- Decrypt:
  - Stimulus: IN_DATA=681edf34d206965e86b3e94f536e4246, IN_DEC=1, same keys.
  - Required response: OUT_DATA=0123456789abcdeffedcba9876543210; RK_IDX steps 31..0.
- Output backpressure: hold OUT_READY=0 for 10 cycles after OUT_VALID -> OUT_DATA stable, IN_READY=0, and IN_VALID held high is not consumed. Releasing OUT_READY gives IDLE the next cycle.
- Reset mid-block: deassert RST_N at round 17 -> outputs return to reset values immediately. A new block after reset still yields the correct ciphertext.
- Input ignored while busy: pulse IN_VALID with a different block during RND_A/RND_B -> result equals the first block's ciphertext only.
- SM4_BLK_CNT_EN defined: 3 completed blocks -> BLK_CNT=3. Force the counter to 0xFFFFFFFF and complete one block -> BLK_CNT=0.

Source files
------------

// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: FSM encoding, round count, block type, S-box table and L transform.
// Pure definitions; no latency or backpressure of its own.
// Imported by sm4_round_ctrl and sm4_round_dp.
package sm4_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RND_A = 2'd1,
        RND_B = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SM4_NR = 32;

    typedef logic [127:0] blk_t;

    localparam int unsigned L_ROT0 = 2;
    localparam int unsigned L_ROT1 = 10;
    localparam int unsigned L_ROT2 = 18;
    localparam int unsigned L_ROT3 = 24;

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int unsigned n);
        return 32'(v << n) | 32'(v >> (32 - n));
    endfunction

    function automatic logic [31:0] l_xform(input logic [31:0] b);
        return b ^ rotl32(b, L_ROT0) ^ rotl32(b, L_ROT1) ^ rotl32(b, L_ROT2) ^ rotl32(b, L_ROT3);
    endfunction

endpackage

// File: rtl/sm4_round_dp.sv
// sm4_round_dp: one SM4 round; XOR into four registered S-boxes, then L transform and X0 mix.
// Latency: S-box stage registers on sbox_ld; nxt is combinational from that register and x0.
// Backpressure: none; the controller decides when the S-box register loads.
module sm4_round_dp
    import sm4_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sbox_ld,
    input  logic [31:0] x0,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic [31:0] x3,
    input  logic [31:0] rk,
    output logic [31:0] nxt
);

    logic [31:0] sbox_in;
    logic [31:0] sbox_q;

    assign sbox_in = x1 ^ x2 ^ x3 ^ rk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbox_q <= '0;
        end else if (sbox_ld) begin
            for (int i = 0; i < 4; i++) begin
                sbox_q[8*i +: 8] <= SBOX[sbox_in[8*i +: 8]];
            end
        end
    end

    assign nxt = x0 ^ l_xform(sbox_q);

endmodule

// File: rtl/sm4_round_ctrl.sv
// sm4_round_ctrl: runs ROUNDS two-cycle SM4 rounds per block, keys fetched by index. Macro SM4_BLK_CNT_EN adds blk_cnt.
// Latency: accept at cycle T, out_valid from T+2*ROUNDS+1; one block in flight at a time.
// Backpressure: in_ready low from accept until the result handshake; out_data held while out_ready low.
module sm4_round_ctrl
    import sm4_pkg::*;
#(
    parameter int ROUNDS = SM4_NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_dec,
    output logic [4:0]   rk_idx,
    input  logic [31:0]  rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
`ifdef SM4_BLK_CNT_EN
   ,output logic [31:0]  blk_cnt
`endif
);

    localparam logic [4:0] RND_LAST = 5'(ROUNDS - 1);

    state_t      state;
    logic        dec_q;
    logic [4:0]  rnd;
    logic [31:0] x0, x1, x2, x3;
    logic [31:0] nxt;

    sm4_round_dp u_dp (
        .clk     (clk),
        .rst_n   (rst_n),
        .sbox_ld (state == RND_A),
        .x0      (x0),
        .x1      (x1),
        .x2      (x2),
        .x3      (x3),
        .rk      (rk),
        .nxt     (nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            rk_idx    <= '0;
            rnd       <= '0;
            dec_q     <= 1'b0;
            x0        <= '0;
            x1        <= '0;
            x2        <= '0;
            x3        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x0       <= in_data[127:96];
                        x1       <= in_data[95:64];
                        x2       <= in_data[63:32];
                        x3       <= in_data[31:0];
                        dec_q    <= in_dec;
                        rnd      <= '0;
                        // key index for round 0 is staged here so it is valid on RND_A entry
                        rk_idx   <= in_dec ? 5'd31 : 5'd0;
                        in_ready <= 1'b0;
                        state    <= RND_A;
                    end
                end
                RND_A: begin
                    state <= RND_B;
                end
                RND_B: begin
                    x0 <= x1;
                    x1 <= x2;
                    x2 <= x3;
                    x3 <= nxt;
                    if (rnd == RND_LAST) begin
                        out_valid <= 1'b1;
                        out_data  <= {nxt, x3, x2, x1};
                        state     <= DONE;
                    end else begin
                        rnd    <= rnd + 5'd1;
                        rk_idx <= dec_q ? (5'd30 - rnd) : (rnd + 5'd1);
                        state  <= RND_A;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

`ifdef SM4_BLK_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt <= '0;
        end else if (out_valid && out_ready) begin
            blk_cnt <= blk_cnt + 32'd1;
        end
    end
`endif

endmodule
